cpr_measure_sequencer: RTL and testbench

Sequencer for the four-channel critical-path-replica (CPR) ring-oscillator monitor. It powers one ring at a time, holds that ring's output divider in reset while the ring settles, then counts rising edges of that ring's divided output over a programmable window of system clocks. Each count is reported as a one-cycle result. The block sits between the power-management register file and the CPR oscillator/divider top. Only one ring runs at any time, and the divider ratio configuration stays static during a measurement.

---
 rtl/cpr_measure_sequencer_if.sv | 40 ++++
 rtl/cpr_measure_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpr_measure_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpr_measure_sequencer_if.sv
// Control/result bundle between the power-management register file and the
// CPR ring-oscillator measurement sequencer.
interface cpr_measure_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic             stop;
    logic             continuous;
    logic [3:0]       chan_mask;
    logic [WIN_W-1:0] window_len;
    logic [1:0]       div_speed_cfg;
    logic [1:0]       div_rc_cfg;
    logic [3:0]       logiccpr;

    logic [3:0]       pd;
    logic             cpr_rn;
    logic [1:0]       divspeed;
    logic [1:0]       divrc;
    logic             busy;
    logic             result_valid;
    logic [1:0]       result_chan;
    logic [CNT_W-1:0] result_count;
    logic             result_ovf;
    logic             done;

    modport slave (
        input  start, stop, continuous, chan_mask, window_len,
               div_speed_cfg, div_rc_cfg, logiccpr,
        output pd, cpr_rn, divspeed, divrc, busy, result_valid,
               result_chan, result_count, result_ovf, done
    );

    modport master (
        output start, stop, continuous, chan_mask, window_len,
               div_speed_cfg, div_rc_cfg, logiccpr,
        input  pd, cpr_rn, divspeed, divrc, busy, result_valid,
               result_chan, result_count, result_ovf, done
    );
endinterface

// File: rtl/cpr_measure_sequencer.sv
// Powers one CPR ring at a time, settles it with the divider held in reset,
// then counts divided-output rising edges over a window of system clocks.
module cpr_measure_sequencer #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rn,
    cpr_measure_sequencer_if.slave  io_bus
);
    localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_REPORT} state_t;

    state_t           r_state, w_state_next;
    logic [3:0]       r_mask;
    logic [WIN_W-1:0] r_win_last;
    logic             r_cont;
    logic [1:0]       r_ch;
    logic [1:0]       r_divspeed, r_divrc;
    logic [TMR_W-1:0] r_tmr;
    logic             r_sync1, r_sync2, r_edge;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [1:0]       r_res_chan;
    logic [CNT_W-1:0] r_res_count;
    logic             r_res_ovf;

    logic             w_latch, w_adv, w_done, w_cpr_rn;
    logic [3:0]       w_pd;
    logic [2:0]       w_above;
    logic             w_det, w_sat;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ovf_next;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        f_lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) f_lowest = 2'(i);
    endfunction

    // {found, index} of the lowest set bit strictly above ch
    function automatic logic [2:0] f_above(input logic [3:0] m, input logic [1:0] ch);
        f_above = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (i > int'(ch))) f_above = {1'b1, 2'(i)};
    endfunction

    assign w_above      = f_above(r_mask, r_ch);
    assign w_det        = r_sync2 & ~r_edge;
    assign w_sat        = (r_count == {CNT_W{1'b1}});
    assign w_count_next = (w_det && !w_sat) ? r_count + CNT_W'(1) : r_count;
    assign w_ovf_next   = r_ovf | (w_det & w_sat);

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_adv        = 1'b0;
        w_done       = 1'b0;
        w_cpr_rn     = 1'b0;
        w_pd         = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start && (io_bus.chan_mask != 4'b0000)) begin
                    w_state_next = ST_SETTLE;
                    w_latch      = 1'b1;
                end
            end
            ST_SETTLE: begin
                w_pd = 4'b0001 << r_ch;
                if (io_bus.stop)
                    w_state_next = ST_IDLE;
                else if (r_tmr == TMR_W'(SETTLE_CYC - 1))
                    w_state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                w_pd     = 4'b0001 << r_ch;
                w_cpr_rn = 1'b1;
                if (io_bus.stop)
                    w_state_next = ST_IDLE;
                else if (r_tmr == TMR_W'(r_win_last))
                    w_state_next = ST_REPORT;
            end
            ST_REPORT: begin
                if (io_bus.stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_above[2] || r_cont) begin
                    w_state_next = ST_SETTLE;
                    w_adv        = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_mask      <= '0;
            r_win_last  <= '0;
            r_cont      <= 1'b0;
            r_ch        <= '0;
            r_divspeed  <= '0;
            r_divrc     <= '0;
            r_tmr       <= '0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_edge      <= 1'b0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_res_chan  <= '0;
            r_res_count <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_mask     <= io_bus.chan_mask;
                r_win_last <= (io_bus.window_len == '0) ? '0 : io_bus.window_len - WIN_W'(1);
                r_cont     <= io_bus.continuous;
                r_ch       <= f_lowest(io_bus.chan_mask);
                r_divspeed <= io_bus.div_speed_cfg;
                r_divrc    <= io_bus.div_rc_cfg;
            end else if (w_adv) begin
                r_ch <= w_above[2] ? w_above[1:0] : f_lowest(r_mask);
            end

            if ((r_state == ST_SETTLE || r_state == ST_MEASURE) && (w_state_next == r_state))
                r_tmr <= r_tmr + TMR_W'(1);
            else
                r_tmr <= '0;

            // synchronizer runs only while a ring is powered, so it is clear on SETTLE entry
            if (r_state == ST_SETTLE || r_state == ST_MEASURE) begin
                r_sync1 <= io_bus.logiccpr[r_ch];
                r_sync2 <= r_sync1;
                r_edge  <= r_sync2;
            end else begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_edge  <= 1'b0;
            end

            if (r_state == ST_MEASURE) begin
                r_count <= w_count_next;
                r_ovf   <= w_ovf_next;
            end else begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end

            // capture includes an edge detected in the final MEASURE cycle
            if (r_state == ST_MEASURE && w_state_next == ST_REPORT) begin
                r_res_chan  <= r_ch;
                r_res_count <= w_count_next;
                r_res_ovf   <= w_ovf_next;
            end
        end
    end

    assign io_bus.pd           = w_pd;
    assign io_bus.cpr_rn       = w_cpr_rn;
    assign io_bus.divspeed     = r_divspeed;
    assign io_bus.divrc        = r_divrc;
    assign io_bus.busy         = (r_state != ST_IDLE);
    assign io_bus.result_valid = (r_state == ST_REPORT);
    assign io_bus.result_chan  = r_res_chan;
    assign io_bus.result_count = r_res_count;
    assign io_bus.result_ovf   = r_res_ovf;
    assign io_bus.done         = w_done;
endmodule

// File: tb/tb_cpr_measure_sequencer.sv
// Self-checking bench for cpr_measure_sequencer: schedule-based reference model
// compared every cycle, plus hand-computed checks for each directed scenario.
module tb_cpr_measure_sequencer;
    localparam int CNT_W  = 4;
    localparam int WIN_W  = 16;
    localparam int S      = 32;
    localparam int MAXC   = 8192;
    localparam int MAXCNT = (1 << CNT_W) - 1;
    localparam int BIG    = 32'h7fffffff;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    int   cyc = 0;
    int   n_checks = 0, n_pass = 0, n_fail = 0;

    cpr_measure_sequencer_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) sif ();

    cpr_measure_sequencer #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(S)) dut (
        .i_clk  (clk),
        .i_rn   (rn),
        .io_bus (sif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ring-output waveform: per-channel period, first rise in cycle gen_start
    int gen_start = BIG;
    int gen_per [4] = '{10, 6, 8, 12};
    initial begin
        logic [3:0] v;
        sif.logiccpr = 4'b0000;
        forever begin
            @(posedge clk);
            #2;
            v = 4'b0000;
            for (int i = 0; i < 4; i++)
                if (cyc >= gen_start) v[i] = ((cyc - gen_start) % gen_per[i]) < (gen_per[i] / 2);
            sif.logiccpr = v;
        end
    end

    // reference model: a run is a list of channels walked on a fixed period
    logic [3:0] lc_hist [0:MAXC-1];
    bit   m_act = 0, m_cont = 0;
    int   m_t0 = 0, m_len = 1, m_w = 1, m_abort = BIG, m_cfg_at = BIG;
    int   m_chans [4];
    logic [1:0] m_dspd = 0, m_drc = 0, m_dspd_p = 0, m_drc_p = 0;
    logic [1:0] m_rchan = 0;
    int   m_rcount = 0;
    bit   m_rovf = 0;

    function automatic void sched(input int m, output int ph, output int ch, output int idx);
        int k, p, q;
        ph = 0; ch = 0; idx = 0;
        if (!m_act || m >= m_abort || m <= m_t0) return;
        p   = S + m_w + 1;
        k   = m - m_t0 - 1;
        idx = k / p;
        if (!m_cont && idx >= m_len) return;
        ch = m_chans[idx % m_len];
        q  = k % p;
        ph = (q < S) ? 1 : (q < S + m_w) ? 2 : 3;
    endfunction

    function automatic int edges_in(input int ch, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if (lc_hist[c][ch] === 1'b1 && lc_hist[c-1][ch] === 1'b0) n++;
        return n;
    endfunction

    always @(negedge clk) begin : compare
        int ph, ch, idx, a, ne;
        bit e_done;
        if (cyc < MAXC) lc_hist[cyc] = sif.logiccpr;
        ph = 0; ch = 0; idx = 0;
        if (!rn) begin
            m_act = 0; m_cfg_at = BIG; m_dspd = 0; m_drc = 0;
            m_rchan = 0; m_rcount = 0; m_rovf = 0;
        end else begin
            if (cyc >= m_cfg_at) begin m_dspd = m_dspd_p; m_drc = m_drc_p; end
            sched(cyc, ph, ch, idx);
        end
        e_done = 0;
        if (ph == 3) begin
            a  = m_t0 + idx * (S + m_w + 1) + S + 1;
            ne = edges_in(ch, a - 2, a + m_w - 3);
            m_rchan  = 2'(ch);
            m_rcount = (ne > MAXCNT) ? MAXCNT : ne;
            m_rovf   = (ne > MAXCNT);
            e_done   = !m_cont && (idx == m_len - 1) && !sif.stop;
            $display("result cyc=%0d chan=%0d count=%0d ovf=%0d done=%0d",
                     cyc, sif.result_chan, sif.result_count, sif.result_ovf, sif.done);
        end
        chk("pd",           sif.pd, (ph == 1 || ph == 2) ? (1 << ch) : 0);
        chk("cpr_rn",       sif.cpr_rn, ph == 2);
        chk("busy",         sif.busy, ph != 0);
        chk("result_valid", sif.result_valid, ph == 3);
        chk("done",         sif.done, e_done);
        chk("result_chan",  sif.result_chan, m_rchan);
        chk("result_count", sif.result_count, m_rcount);
        chk("result_ovf",   sif.result_ovf, m_rovf);
        chk("divspeed",     sif.divspeed, m_dspd);
        chk("divrc",        sif.divrc, m_drc);
        if (rn) begin
            if (ph == 0 && sif.start && sif.chan_mask != 4'b0000) begin
                m_act = 1; m_t0 = cyc; m_abort = BIG; m_cont = sif.continuous;
                m_w = (sif.window_len == 0) ? 1 : int'(sif.window_len);
                m_len = 0;
                for (int i = 0; i < 4; i++)
                    if (sif.chan_mask[i]) begin m_chans[m_len] = i; m_len++; end
                m_dspd_p = sif.div_speed_cfg; m_drc_p = sif.div_rc_cfg; m_cfg_at = cyc + 1;
            end else if (ph != 0 && sif.stop) begin
                m_abort = cyc + 1;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); #2; end
    endtask

    task automatic go(input logic [3:0] mask, input int w, input bit cont,
                      input logic [1:0] ds, input logic [1:0] dr, output int t0);
        sif.chan_mask = mask; sif.window_len = WIN_W'(w); sif.continuous = cont;
        sif.div_speed_cfg = ds; sif.div_rc_cfg = dr; sif.start = 1'b1;
        t0 = cyc;
        tick(1);
        sif.start = 1'b0;
    endtask

    task automatic wait_rv(input int limit, output int at);
        int k = 0;
        while (!sif.result_valid && k < limit) begin tick(1); k++; end
        chk("result_valid_seen", sif.result_valid, 1);
        at = cyc;
    endtask

    initial begin
        int t0, a1, a2, a3, seen;
        sif.start = 0; sif.stop = 0; sif.continuous = 0; sif.chan_mask = 0;
        sif.window_len = 0; sif.div_speed_cfg = 0; sif.div_rc_cfg = 0;
        tick(2);
        chk("rst_pd", sif.pd, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_count", sif.result_count, 0);
        chk("rst_divrc", sif.divrc, 0);
        rn = 1'b1;
        tick(2);

        // start with an empty mask is ignored
        go(4'b0000, 10, 0, 1, 1, t0);
        chk("empty_mask_busy", sif.busy, 0);
        tick(2);

        // single channel, W=100, edges every 10 from cycle 33
        gen_start = cyc + 33;
        go(4'b0001, 100, 0, 2, 1, t0);
        chk("t1_pd", sif.pd, 4'b0001);
        chk("t1_cpr_rn", sif.cpr_rn, 0);
        chk("t1_divspeed", sif.divspeed, 2);
        wait_rv(300, a1);
        chk("t1_latency", a1 - t0, 133);
        chk("t1_chan", sif.result_chan, 0);
        chk("t1_count", sif.result_count, 10);
        chk("t1_ovf", sif.result_ovf, 0);
        chk("t1_done", sif.done, 1);
        tick(1);
        chk("t1_idle", sif.busy, 0);

        // mask scan 0101, W=50
        tick(3);
        gen_start = cyc + 5;
        go(4'b0101, 50, 0, 1, 2, t0);
        wait_rv(300, a1);
        chk("t2_chan_a", sif.result_chan, 0);
        chk("t2_done_a", sif.done, 0);
        tick(1);
        wait_rv(300, a2);
        chk("t2_spacing", a2 - a1, 83);
        chk("t2_chan_b", sif.result_chan, 2);
        chk("t2_done_b", sif.done, 1);

        // saturation: 4-bit count, W=200, edge every 4
        tick(3);
        gen_per[0] = 4;
        gen_start = cyc + 33;
        go(4'b0001, 200, 0, 0, 0, t0);
        wait_rv(400, a1);
        chk("t3_count", sif.result_count, 15);
        chk("t3_ovf", sif.result_ovf, 1);

        // abort in MEASURE cycle 20
        tick(3);
        gen_per[0] = 10;
        go(4'b0011, 100, 0, 1, 2, t0);
        tick(51);
        sif.stop = 1'b1;
        tick(1);
        sif.stop = 1'b0;
        chk("t4_pd", sif.pd, 0);
        chk("t4_cpr_rn", sif.cpr_rn, 0);
        chk("t4_busy", sif.busy, 0);
        seen = 0;
        repeat (150) begin tick(1); if (sif.result_valid || sif.done) seen++; end
        chk("t4_quiet", seen, 0);

        // continuous on ring 4 with start+stop together, config changed while busy
        gen_per[3] = 6;
        sif.stop = 1'b1;
        go(4'b1000, 20, 1, 0, 0, t0);
        sif.stop = 1'b0;
        sif.div_rc_cfg = 3; sif.div_speed_cfg = 3;
        chk("t5_start_wins", sif.busy, 1);
        wait_rv(200, a1);
        chk("t5_chan", sif.result_chan, 3);
        chk("t5_no_done", sif.done, 0);
        tick(1);
        wait_rv(200, a2);
        chk("t5_period_a", a2 - a1, 53);
        tick(1);
        wait_rv(200, a3);
        chk("t5_period_b", a3 - a2, 53);
        chk("t5_divrc_locked", sif.divrc, 0);
        tick(10);
        sif.stop = 1'b1;
        tick(1);
        sif.stop = 1'b0;
        chk("t5_stopped", sif.busy, 0);
        chk("t5_divrc_after_stop", sif.divrc, 0);
        tick(2);
        go(4'b1000, 20, 0, 1, 3, t0);
        chk("t5_divrc_new", sif.divrc, 3);
        chk("t5_divspeed_new", sif.divspeed, 1);
        wait_rv(200, a1);
        chk("t5_final_done", sif.done, 1);

        // asynchronous reset during SETTLE of ring 2, then a clean restart with W=0
        tick(2);
        go(4'b0010, 30, 0, 2, 1, t0);
        tick(9);
        #1 rn = 1'b0;
        #1;
        chk("t6_pd", sif.pd, 0);
        chk("t6_busy", sif.busy, 0);
        chk("t6_count", sif.result_count, 0);
        chk("t6_divspeed", sif.divspeed, 0);
        tick(2);
        rn = 1'b1;
        tick(2);
        go(4'b0010, 0, 0, 0, 0, t0);
        chk("t6_restart_pd", sif.pd, 4'b0010);
        chk("t6_restart_rn", sif.cpr_rn, 0);
        wait_rv(100, a1);
        chk("t6_latency", a1 - t0, 34);
        chk("t6_chan", sif.result_chan, 1);
        chk("t6_done", sif.done, 1);
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
